// File: rtl/comp_sched_pkg.sv
// Shared constants and helpers for the comparator-sharing scheduler.
//   CMP_W   : comparator operand width
//   CMP_NCH : default number of requesting channels
//   CMP_LAT : comparator latency, operand sample edge to result valid
//   clog2   : ceiling log2, used to size channel ids
package comp_sched_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    localparam int unsigned CMP_W   = 20;
    localparam int unsigned CMP_NCH = 4;
    localparam int unsigned CMP_LAT = 2;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter with internal pointer.
//   clk, rst_n : clock, async active-low reset
//   en         : 1 = a grant may be issued this cycle
//   req        : per-channel request levels
//   gnt        : one-hot grant (combinational)
//   id         : encoded id of the granted channel (valid when vld=1)
//   vld        : a grant is issued this cycle
module rr_arb
    import comp_sched_pkg::*;
#(
    parameter int unsigned NCH = CMP_NCH,
    parameter int unsigned CHW = clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [CHW-1:0] id,
    output logic           vld
);

    localparam logic [CHW:0]   NCH_V  = (CHW+1)'(NCH);
    localparam logic [CHW-1:0] LAST_V = CHW'(NCH - 1);

    logic [CHW-1:0]   ptr;
    logic [2*NCH-1:0] req2;
    logic [NCH-1:0]   rot;
    logic [CHW-1:0]   off;
    logic             hit;
    logic [CHW:0]     sum;

    // Rotate requests so ptr sits at bit 0, pick the lowest set bit, rotate back.
    always_comb begin
        req2 = {req, req} >> ptr;
        rot  = req2[NCH-1:0];
        off  = '0;
        hit  = 1'b0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = CHW'(i);
                hit = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NCH_V) sum = sum - NCH_V;
        id  = sum[CHW-1:0];
        vld = hit & en;
        gnt = vld ? (NCH'(1) << id) : '0;
    end

    // Pointer moves to the channel after the one just granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (vld) begin
            ptr <= (id == LAST_V) ? '0 : id + 1'b1;
        end
    end

endmodule

// File: rtl/comp_share_sched.sv
// Round-robin scheduler sharing one registered comparator among NCH channels.
//   Clock, Reset      : clock, async active-low reset
//   Hold              : 1 = no new grants, in-flight results still return
//   Req, Op_A, Op_B   : per-channel request and packed operands
//   Gnt               : one-hot grant, combinational, same cycle as issue
//   Comp_A, Comp_B    : operands to the comparator (last issued when idle)
//   Comp_out          : comparator result
//   Res_valid/ch/bit  : registered result return, LAT+1 cycles after grant
//   Res_word          : sticky last result bit per channel
//   Busy              : any issue in flight
module comp_share_sched
    import comp_sched_pkg::*;
#(
    parameter int unsigned NCH = CMP_NCH,
    parameter int unsigned W   = CMP_W,
    parameter int unsigned LAT = CMP_LAT,
    parameter int unsigned CHW = clog2(NCH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Hold,
    input  logic [NCH-1:0]   Req,
    input  logic [NCH*W-1:0] Op_A,
    input  logic [NCH*W-1:0] Op_B,
    output logic [NCH-1:0]   Gnt,
    output logic [W-1:0]     Comp_A,
    output logic [W-1:0]     Comp_B,
    input  logic             Comp_out,
    output logic             Res_valid,
    output logic [CHW-1:0]   Res_ch,
    output logic             Res_bit,
    output logic [NCH-1:0]   Res_word,
    output logic             Busy
);

    logic [NCH-1:0]          arb_gnt;
    logic [CHW-1:0]          arb_id;
    logic                    arb_vld;
    logic [W-1:0]            sel_a;
    logic [W-1:0]            sel_b;
    logic [W-1:0]            last_a;
    logic [W-1:0]            last_b;
    logic [LAT-1:0]          tag_v;
    logic [LAT-1:0][CHW-1:0] tag_ch;

    // Reset gates the enable so no grant is shown while Reset is low.
    rr_arb #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .clk   (Clock),
        .rst_n (Reset),
        .en    (~Hold & Reset),
        .req   (Req),
        .gnt   (arb_gnt),
        .id    (arb_id),
        .vld   (arb_vld)
    );

    assign Gnt = arb_gnt;

    // Operand mux; idle cycles replay the last issued operands.
    always_comb begin
        sel_a  = Op_A[arb_id*W +: W];
        sel_b  = Op_B[arb_id*W +: W];
        Comp_A = arb_vld ? sel_a : last_a;
        Comp_B = arb_vld ? sel_b : last_b;
    end

    // Tag pipe tracks comparator latency; result stage adds one flop.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            last_a    <= '0;
            last_b    <= '0;
            tag_v     <= '0;
            tag_ch    <= '0;
            Res_valid <= 1'b0;
            Res_ch    <= '0;
            Res_bit   <= 1'b0;
            Res_word  <= '0;
        end else begin
            if (arb_vld) begin
                last_a <= sel_a;
                last_b <= sel_b;
            end
            tag_v[0]  <= arb_vld;
            tag_ch[0] <= arb_id;
            for (int i = 1; i < int'(LAT); i++) begin
                tag_v[i]  <= tag_v[i-1];
                tag_ch[i] <= tag_ch[i-1];
            end
            Res_valid <= tag_v[LAT-1];
            if (tag_v[LAT-1]) begin
                Res_ch                   <= tag_ch[LAT-1];
                Res_bit                  <= Comp_out;
                Res_word[tag_ch[LAT-1]]  <= Comp_out;
            end
        end
    end

    assign Busy = |tag_v;

endmodule

// File: tb/tb_comp_share_sched.sv
// Directed + randomised bench for comp_share_sched with a 2-stage A>B comparator model.
module tb_comp_share_sched;

    logic        Clock;
    logic        Reset;
    logic        Hold;
    logic [3:0]  Req;
    logic [79:0] Op_A;
    logic [79:0] Op_B;
    logic [3:0]  Gnt;
    logic [19:0] Comp_A;
    logic [19:0] Comp_B;
    logic        Comp_out;
    logic        Res_valid;
    logic [1:0]  Res_ch;
    logic        Res_bit;
    logic [3:0]  Res_word;
    logic        Busy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] ch;
        logic       b;
        int         cyc;
    } exp_t;

    exp_t q[$];

    comp_share_sched dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Hold      (Hold),
        .Req       (Req),
        .Op_A      (Op_A),
        .Op_B      (Op_B),
        .Gnt       (Gnt),
        .Comp_A    (Comp_A),
        .Comp_B    (Comp_B),
        .Comp_out  (Comp_out),
        .Res_valid (Res_valid),
        .Res_ch    (Res_ch),
        .Res_bit   (Res_bit),
        .Res_word  (Res_word),
        .Busy      (Busy)
    );

    // Comparator model: out = (A > B), two register stages.
    logic p1, p2;
    always @(posedge Clock) begin
        p1 <= (Comp_A > Comp_B);
        p2 <= p1;
    end
    assign Comp_out = p2;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic test_reset();
        Reset = 1'b0; Hold = 1'b0; Req = 4'b1111; Op_A = '0; Op_B = '0;
        step(); step(); settle();
        checks++;
        if ({Gnt, Res_valid, Res_ch, Res_bit, Res_word, Busy} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outs got gnt=%b rv=%b ch=%0d bit=%b word=%b busy=%b exp all 0",
                     Gnt, Res_valid, Res_ch, Res_bit, Res_word, Busy);
        end
        checks++;
        if ({Comp_A, Comp_B} !== 40'd0) begin
            failures++;
            $display("FAIL reset_ops got A=%h B=%h exp 0", Comp_A, Comp_B);
        end
        for (int c = 0; c < 5; c++) begin
            step();
            Reset = 1'b1; Req = 4'b0000;
            settle();
            checks++;
            if ({Gnt, Res_valid, Busy} !== 6'd0) begin
                failures++;
                $display("FAIL idle c=%0d got gnt=%b rv=%b busy=%b exp 0", c, Gnt, Res_valid, Busy);
            end
        end
    endtask

    task automatic test_rr_all();
        logic [3:0] eg;
        logic [3:0] bits;
        int         ech;
        bits = 4'b1011;
        // ch3 9>1, ch2 0>0, ch1 3>2, ch0 7>0
        Op_A = {20'd9, 20'd0, 20'd3, 20'd7};
        Op_B = {20'd1, 20'd0, 20'd2, 20'd0};
        for (int c = 0; c < 10; c++) begin
            step();
            Req = (c < 5) ? 4'b1111 : 4'b0000;
            settle();
            eg = (c < 5) ? (4'b0001 << (c % 4)) : 4'b0000;
            checks++;
            if (Gnt !== eg) begin
                failures++;
                $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, Gnt, eg);
            end
            checks++;
            if (Res_valid !== (c >= 3 && c < 8)) begin
                failures++;
                $display("FAIL rr_rv c=%0d got=%b", c, Res_valid);
            end
            if (c >= 3 && c < 8) begin
                ech = (c - 3) % 4;
                checks++;
                if (Res_ch !== 2'(ech) || Res_bit !== bits[ech]) begin
                    failures++;
                    $display("FAIL rr_res c=%0d got ch=%0d bit=%b exp ch=%0d bit=%b",
                             c, Res_ch, Res_bit, ech, bits[ech]);
                end
            end
            checks++;
            if (Busy !== (c >= 1 && c <= 6)) begin
                failures++;
                $display("FAIL rr_busy c=%0d got=%b", c, Busy);
            end
            if (c == 1) begin
                checks++;
                if (Comp_A !== 20'd3 || Comp_B !== 20'd2) begin
                    failures++;
                    $display("FAIL rr_ops got A=%h B=%h exp A=3 B=2", Comp_A, Comp_B);
                end
            end
        end
        checks++;
        if (Res_word !== 4'b1011) begin
            failures++;
            $display("FAIL rr_word got=%b exp=1011", Res_word);
        end
    endtask

    task automatic test_result_bits();
        logic [3:0]  rq;
        logic [19:0] ea, eb;
        logic [3:0]  ew;
        // ptr is 1 here; ch2: FFFFF>1 -> 1, ch0: 1>5 -> 0
        Op_A = {20'd0, 20'hFFFFF, 20'd0, 20'd1};
        Op_B = {20'd0, 20'd1, 20'd0, 20'd5};
        for (int c = 0; c < 6; c++) begin
            step();
            rq = (c == 0) ? 4'b0100 : (c == 1) ? 4'b0001 : 4'b0000;
            Req = rq;
            settle();
            checks++;
            if (Gnt !== rq) begin
                failures++;
                $display("FAIL bits_gnt c=%0d got=%b exp=%b", c, Gnt, rq);
            end
            ea = (c == 0) ? 20'hFFFFF : 20'd1;
            eb = (c == 0) ? 20'd1 : 20'd5;
            checks++;
            if (Comp_A !== ea || Comp_B !== eb) begin
                failures++;
                $display("FAIL bits_ops c=%0d got A=%h B=%h exp A=%h B=%h", c, Comp_A, Comp_B, ea, eb);
            end
            checks++;
            if (Res_valid !== (c == 3 || c == 4)) begin
                failures++;
                $display("FAIL bits_rv c=%0d got=%b", c, Res_valid);
            end
            if (c == 3) begin
                checks++;
                if (Res_ch !== 2'd2 || Res_bit !== 1'b1) begin
                    failures++;
                    $display("FAIL bits_res2 got ch=%0d bit=%b exp ch=2 bit=1", Res_ch, Res_bit);
                end
            end
            if (c == 4) begin
                checks++;
                if (Res_ch !== 2'd0 || Res_bit !== 1'b0) begin
                    failures++;
                    $display("FAIL bits_res0 got ch=%0d bit=%b exp ch=0 bit=0", Res_ch, Res_bit);
                end
            end
            ew = (c < 3) ? 4'b1011 : (c == 3) ? 4'b1111 : 4'b1110;
            checks++;
            if (Res_word !== ew) begin
                failures++;
                $display("FAIL bits_word c=%0d got=%b exp=%b", c, Res_word, ew);
            end
        end
    endtask

    task automatic test_wrap_hold();
        logic [3:0] eg;
        for (int c = 0; c < 9; c++) begin
            step();
            Req  = (c == 0) ? 4'b0101 : (c <= 5) ? 4'b0001 : 4'b0000;
            Hold = (c >= 2 && c <= 4);
            settle();
            eg = (c == 0) ? 4'b0100 : (c == 1 || c == 5) ? 4'b0001 : 4'b0000;
            checks++;
            if (Gnt !== eg) begin
                failures++;
                $display("FAIL wrap_gnt c=%0d got=%b exp=%b", c, Gnt, eg);
            end
            checks++;
            if (Res_valid !== (c == 3 || c == 4 || c == 8)) begin
                failures++;
                $display("FAIL wrap_rv c=%0d got=%b", c, Res_valid);
            end
            if (c == 3 || c == 4 || c == 8) begin
                checks++;
                if (Res_ch !== ((c == 3) ? 2'd2 : 2'd0) || Res_bit !== (c == 3)) begin
                    failures++;
                    $display("FAIL wrap_res c=%0d got ch=%0d bit=%b", c, Res_ch, Res_bit);
                end
            end
            checks++;
            if (Busy !== ((c >= 1 && c <= 3) || c == 6 || c == 7)) begin
                failures++;
                $display("FAIL wrap_busy c=%0d got=%b", c, Busy);
            end
        end
    endtask

    task automatic test_reset_midflight();
        logic [3:0] eg;
        for (int c = 0; c < 13; c++) begin
            step();
            Req   = (c <= 1 || c == 3 || c == 8) ? 4'b1111 : 4'b0000;
            Reset = !(c == 2 || c == 3);
            settle();
            eg = (c == 0) ? 4'b0010 : (c == 1) ? 4'b0100 : (c == 8) ? 4'b0001 : 4'b0000;
            checks++;
            if (Gnt !== eg) begin
                failures++;
                $display("FAIL mid_gnt c=%0d got=%b exp=%b", c, Gnt, eg);
            end
            checks++;
            if (Res_valid !== (c == 11)) begin
                failures++;
                $display("FAIL mid_rv c=%0d got=%b", c, Res_valid);
            end
            if (c == 2) begin
                checks++;
                if (Busy !== 1'b0 || Res_word !== 4'b0000) begin
                    failures++;
                    $display("FAIL mid_clear got busy=%b word=%b exp 0", Busy, Res_word);
                end
            end
            if (c == 11) begin
                checks++;
                if (Res_ch !== 2'd0 || Res_bit !== 1'b0) begin
                    failures++;
                    $display("FAIL mid_res got ch=%0d bit=%b exp ch=0 bit=0", Res_ch, Res_bit);
                end
            end
        end
    endtask

    task automatic test_random();
        int         ptr_m;
        int         ch;
        logic [3:0] eg;
        logic       erv;
        exp_t       e;
        step();
        Reset = 1'b0; Req = 4'b0000; Hold = 1'b0;
        step();
        Reset = 1'b1;
        ptr_m = 0;
        q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            step();
            if (cyc < 9990) begin
                Req  = 4'($urandom);
                Hold = ($urandom_range(0, 3) == 0);
                for (int i = 0; i < 4; i++) begin
                    Op_A[i*20 +: 20] = 20'($urandom);
                    Op_B[i*20 +: 20] = 20'($urandom);
                end
            end else begin
                Req  = 4'b0000;
                Hold = 1'b0;
            end
            settle();
            erv = (q.size() != 0) && (q[0].cyc + 3 == cyc);
            checks++;
            if (Res_valid !== erv) begin
                failures++;
                $display("FAIL rnd_rv cyc=%0d got=%b exp=%b", cyc, Res_valid, erv);
            end
            if (erv) begin
                e = q.pop_front();
                checks++;
                if (Res_ch !== e.ch || Res_bit !== e.b) begin
                    failures++;
                    $display("FAIL rnd_res cyc=%0d got ch=%0d bit=%b exp ch=%0d bit=%b",
                             cyc, Res_ch, Res_bit, e.ch, e.b);
                end
            end
            ch = -1;
            if (!Hold) begin
                for (int i = 0; i < 4; i++) begin
                    if (ch < 0 && Req[(ptr_m + i) % 4]) ch = (ptr_m + i) % 4;
                end
            end
            eg = (ch >= 0) ? (4'b0001 << ch) : 4'b0000;
            checks++;
            if (Gnt !== eg) begin
                failures++;
                $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, Gnt, eg);
            end
            if (ch >= 0) begin
                e.ch  = 2'(ch);
                e.b   = (Op_A[ch*20 +: 20] > Op_B[ch*20 +: 20]);
                e.cyc = cyc;
                q.push_back(e);
                ptr_m = (ch + 1) % 4;
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL rnd_drain got pending=%0d exp 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_rr_all();
        test_result_bits();
        test_wrap_hold();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
